// File: rtl/rom_access_arbiter.sv
// Single-port instruction ROM arbiter: shares the ROM between the core fetch
// path and a program-loader write channel. Loader writes win, but a burst
// limit guarantees a pending fetch is granted at least every MAX_BURST+1 cycles.
module rom_access_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROM_DEPTH = 4096,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              i_Clk,
    input  logic              i_reset_n,
    // fetch requester
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic [DATA_W-1:0] o_fetch_data,
    output logic              o_fetch_valid,
    output logic              o_hold_flag,
    // loader write channel
    input  logic              i_ld_valid,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_ld_ready,
    output logic              o_ld_err,
    input  logic              i_err_clr,
    output logic [15:0]       o_ld_count,
    // ROM pins
    output logic              o_rom_ce,
    output logic              o_rom_we,
    output logic [ADDR_W-1:0] o_rom_w_addr,
    output logic [DATA_W-1:0] o_rom_w_data,
    output logic [ADDR_W-1:0] o_rom_r_addr,
    input  logic [DATA_W-1:0] i_rom_r_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    // One bit wider than the address so the limit itself is representable.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(ROM_DEPTH * 4);
    localparam logic [3:0]      BURST_LIM  = 4'(MAX_BURST);

    logic [1:0]        state_q, state_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              ld_err_q, ld_err_d;
    logic [15:0]       ld_count_q, ld_count_d;

    logic ld_gnt;
    logic fe_gnt;
    logic ld_legal;

    // Grant decision; gated by reset so nothing reaches the ROM pins while in reset.
    always_comb begin
        ld_gnt   = i_reset_n & i_ld_valid & ((burst_cnt_q < BURST_LIM) | ~i_fetch_req);
        fe_gnt   = i_reset_n & i_fetch_req & ~ld_gnt;
        ld_legal = (i_ld_addr[1:0] == 2'b00) & ({1'b0, i_ld_addr} < ADDR_LIMIT);
    end

    // ROM pin and handshake outputs for the granted requester.
    always_comb begin
        o_fetch_gnt   = fe_gnt;
        o_ld_ready    = ld_gnt;
        o_hold_flag   = i_reset_n & i_fetch_req & ~fe_gnt;
        o_rom_ce      = ld_gnt | fe_gnt;
        o_rom_we      = ld_gnt & ld_legal;
        o_rom_w_addr  = ld_gnt ? i_ld_addr : '0;
        o_rom_w_data  = ld_gnt ? i_ld_data : '0;
        o_rom_r_addr  = fe_gnt ? i_fetch_addr : '0;
        // The state remembers last cycle's grant, so a fetch grant last cycle
        // means the registered word is fresh now.
        o_fetch_valid = (state_q == S_FETCH);
        o_fetch_data  = fetch_data_q;
        o_ld_err      = ld_err_q;
        o_ld_count    = ld_count_q;
    end

    // Next-state: grant record, burst counter, fetch capture, error and count.
    always_comb begin
        state_d      = S_IDLE;
        burst_cnt_d  = '0;
        fetch_data_d = fetch_data_q;
        ld_err_d     = ld_err_q;
        ld_count_d   = ld_count_q;

        if (ld_gnt) begin
            state_d = S_LOAD;
            burst_cnt_d = (burst_cnt_q < BURST_LIM) ? burst_cnt_q + 4'd1 : burst_cnt_q;
        end else if (fe_gnt) begin
            state_d      = S_FETCH;
            fetch_data_d = i_rom_r_data;
        end

        if (ld_gnt && ld_legal) begin
            ld_count_d = ld_count_q + 16'd1;
        end

        // An illegal beat wins over a clear in the same cycle.
        if (ld_gnt && !ld_legal) begin
            ld_err_d = 1'b1;
        end else if (i_err_clr) begin
            ld_err_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            burst_cnt_q  <= '0;
            fetch_data_q <= '0;
            ld_err_q     <= 1'b0;
            ld_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            fetch_data_q <= fetch_data_d;
            ld_err_q     <= ld_err_d;
            ld_count_q   <= ld_count_d;
        end
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: directed scenarios followed by
// randomized traffic, checked against a cycle-level reference of the grant rules.
module tb_rom_access_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        hold_flag;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_err;
    logic        err_clr;
    logic [15:0] ld_count;
    logic        rom_ce;
    logic        rom_we;
    logic [31:0] rom_w_addr;
    logic [31:0] rom_w_data;
    logic [31:0] rom_r_addr;
    logic [31:0] rom_r_data;

    rom_access_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .ROM_DEPTH(4096),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .i_Clk        (clk),
        .i_reset_n    (rst_n),
        .i_fetch_req  (fetch_req),
        .i_fetch_addr (fetch_addr),
        .o_fetch_gnt  (fetch_gnt),
        .o_fetch_data (fetch_data),
        .o_fetch_valid(fetch_valid),
        .o_hold_flag  (hold_flag),
        .i_ld_valid   (ld_valid),
        .i_ld_addr    (ld_addr),
        .i_ld_data    (ld_data),
        .o_ld_ready   (ld_ready),
        .o_ld_err     (ld_err),
        .i_err_clr    (err_clr),
        .o_ld_count   (ld_count),
        .o_rom_ce     (rom_ce),
        .o_rom_we     (rom_we),
        .o_rom_w_addr (rom_w_addr),
        .o_rom_w_data (rom_w_data),
        .o_rom_r_addr (rom_r_addr),
        .i_rom_r_data (rom_r_data)
    );

    always #5 clk = ~clk;

    // Physical ROM the DUT drives.
    logic [31:0] rom [0:4095];
    assign rom_r_data = rom[rom_r_addr[13:2]];
    always @(posedge clk) begin
        if (rom_ce && rom_we) rom[rom_w_addr[13:2]] <= rom_w_data;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:4095];
    int          streak;      // consecutive loader grants, unbounded
    logic [15:0] m_count;
    logic        m_err;
    logic        m_valid;
    logic [31:0] m_data;
    logic        last_l, last_f;
    string       pat;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        streak  = 0;
        m_count = '0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // One clock: inputs already applied at posedge+1.
    task automatic step(input string tag);
        bit lw, fw, legal;
        lw    = ld_valid && ((streak < MAX_BURST) || !fetch_req);
        fw    = !lw && fetch_req;
        legal = (ld_addr[1:0] == 2'b00) && (ld_addr < 32'h4000);
        #1;
        chk({tag, "/ready"}, ld_ready, lw);
        chk({tag, "/gnt"}, fetch_gnt, fw);
        chk({tag, "/hold"}, hold_flag, fetch_req && !fw);
        chk({tag, "/ce"}, rom_ce, lw || fw);
        chk({tag, "/we"}, rom_we, lw && legal);
        chk({tag, "/waddr"}, rom_w_addr, lw ? ld_addr : 32'h0);
        chk({tag, "/raddr"}, rom_r_addr, fw ? fetch_addr : 32'h0);
        last_l = lw;
        last_f = fw;
        pat = {pat, lw ? "L" : (fw ? "F" : "-")};
        @(posedge clk);
        streak = lw ? streak + 1 : 0;
        if (lw && legal) begin
            ref_mem[ld_addr[13:2]] = ld_data;
            m_count = m_count + 16'd1;
        end
        if (lw && !legal) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_valid = fw;
        if (fw) m_data = ref_mem[fetch_addr[13:2]];
        #1;
        chk({tag, "/valid"}, fetch_valid, m_valid);
        chk({tag, "/data"}, fetch_data, m_data);
        chk({tag, "/count"}, ld_count, m_count);
        chk({tag, "/err"}, ld_err, m_err);
    endtask

    initial begin
        logic [31:0] keep_word;
        int k;
        int r;

        for (int i = 0; i < 4096; i++) begin
            rom[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        rom[4]     = 32'h1010;
        ref_mem[4] = 32'h1010;

        // Reset with both requesters active: everything must stay quiet.
        rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h10;
        ld_valid = 1'b1; ld_addr = 32'h20; ld_data = 32'h5; err_clr = 1'b0;
        last_l = 1'b0; last_f = 1'b0; pat = "";
        model_reset();
        #12;
        chk("rst/ce", rom_ce, 1'b0);
        chk("rst/we", rom_we, 1'b0);
        chk("rst/ready", ld_ready, 1'b0);
        chk("rst/gnt", fetch_gnt, 1'b0);
        chk("rst/hold", hold_flag, 1'b0);
        chk("rst/valid", fetch_valid, 1'b0);
        chk("rst/data", fetch_data, 32'h0);
        chk("rst/count", ld_count, 16'h0);
        chk("rst/err", ld_err, 1'b0);
        ld_valid = 1'b0; fetch_req = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch only.
        fetch_req = 1'b1; fetch_addr = 32'h10;
        step("fetch0");
        chk("fetch0/word", fetch_data, 32'h1010);
        step("fetch1");
        fetch_req = 1'b0;

        // Loader only, three beats.
        ld_valid = 1'b1; ld_data = 32'h1010;
        ld_addr = 32'h10; step("ld0");
        ld_addr = 32'h18; step("ld1");
        ld_addr = 32'h2c; step("ld2");
        ld_valid = 1'b0;
        chk("ld/count3", ld_count, 16'd3);
        fetch_req = 1'b1;
        fetch_addr = 32'h18; step("rd18");
        chk("rd18/word", fetch_data, 32'h1010);
        fetch_addr = 32'h2c; step("rd2c");
        chk("rd2c/word", fetch_data, 32'h1010);

        // Contention: loader held valid while fetch keeps requesting.
        fetch_addr = 32'h40; pat = ""; k = 0;
        for (int c = 0; c < 20 && k < 10; c++) begin
            ld_valid = 1'b1;
            ld_addr  = 32'(32'h200 + k * 4);
            ld_data  = 32'(32'hC0DE_0000 + k);
            step("cont");
            if (last_l) k++;
        end
        ld_valid = 1'b0; fetch_req = 1'b0;
        n_vec++;
        assert (pat.substr(0, 9) == "LLLLFLLLLF") else begin
            n_err++;
            $error("FAIL cont/pattern: observed %s expected LLLLFLLLLF", pat);
        end
        chk("cont/beats", k, 10);
        chk("cont/count13", ld_count, 16'd13);

        // Illegal addresses and error clear priority.
        ld_valid = 1'b1; ld_data = 32'hDEAD;
        ld_addr = 32'h12;   step("ill_mis");
        ld_addr = 32'h4000; step("ill_oor");
        chk("ill/count", ld_count, 16'd13);
        chk("ill/err", ld_err, 1'b1);
        ld_valid = 1'b0; err_clr = 1'b1; step("clr");
        chk("clr/err", ld_err, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h12; step("ill_clr");
        chk("ill_clr/err", ld_err, 1'b1);
        ld_valid = 1'b0; step("clr2");
        err_clr = 1'b0;

        // Asynchronous reset in the middle of the second burst beat.
        ld_valid = 1'b1; ld_addr = 32'h100; ld_data = 32'h1111_1111;
        step("mid0");
        ld_addr = 32'h104; ld_data = 32'h2222_2222;
        keep_word = ref_mem[65];
        #2 rst_n = 1'b0;
        #1;
        chk("mid/ce", rom_ce, 1'b0);
        chk("mid/we", rom_we, 1'b0);
        chk("mid/ready", ld_ready, 1'b0);
        chk("mid/count", ld_count, 16'h0);
        chk("mid/err", ld_err, 1'b0);
        chk("mid/valid", fetch_valid, 1'b0);
        chk("mid/data", fetch_data, 32'h0);
        @(posedge clk); #1;
        chk("mid/nowrite", rom[65], keep_word);
        model_reset();
        ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h104;
        #3 rst_n = 1'b1;
        step("post0");
        chk("post0/word", fetch_data, keep_word);
        ld_valid = 1'b1; ld_addr = 32'h108; ld_data = 32'h3333;
        for (int c = 0; c < 6; c++) begin
            step("post");
            if (last_l) begin
                ld_addr = ld_addr + 32'h4;
            end
        end

        // Randomized traffic; requesters hold until granted.
        for (int i = 0; i < 400; i++) begin
            if (!ld_valid || last_l) begin
                ld_valid = ($urandom_range(0, 2) != 0);
                r = $urandom_range(0, 7);
                if (r == 0) ld_addr = 32'(32'h4000 + $urandom_range(0, 255) * 4);
                else if (r == 1) ld_addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                else ld_addr = 32'($urandom_range(0, 63) * 4);
                ld_data = $urandom;
            end
            if (!fetch_req || last_f) begin
                fetch_req  = ($urandom_range(0, 1) != 0);
                fetch_addr = 32'($urandom_range(0, 63) * 4);
            end
            err_clr = ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        // Count wrap: 65536 legal writes starting from a fresh reset.
        ld_valid = 1'b0; fetch_req = 1'b0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            ld_addr = 32'((i % 4096) * 4);
            ld_data = 32'(i);
            @(posedge clk); #1;
        end
        chk("wrap/ffff", ld_count, 16'hFFFF);
        ld_addr = 32'h0;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        chk("wrap/zero", ld_count, 16'h0);
        chk("wrap/err", ld_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
